// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one palette ROM between pixel requesters.
// Grant is combinational; the colour returns to the winner two cycles after its grant.
module palette_lookup_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 4,
  parameter int CW    = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*IDX_W-1:0] index,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]       pal_index,
  input  logic [CW-1:0]          pal_red,
  input  logic [CW-1:0]          pal_green,
  input  logic [CW-1:0]          pal_blue,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [CW-1:0]          rsp_red,
  output logic [CW-1:0]          rsp_green,
  output logic [CW-1:0]          rsp_blue,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    winner;
  logic [PW:0]      cand;
  logic             accept;
  logic [IDX_W-1:0] pal_index_q, win_index;
  logic             s1_valid_q;
  logic [PW-1:0]    s1_owner_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [3*CW-1:0]  rsp_rgb_q;

  // Scan from the pointer, wrapping; the first requester found wins.
  always_comb begin
    winner = '0;
    accept = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!accept && !flush && req[cand[PW-1:0]]) begin
        accept = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    win_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == PW'(i)) win_index = index[i*IDX_W +: IDX_W];
    end
  end

  assign gnt      = accept ? (N_REQ'(1) << winner) : '0;
  assign rr_ptr_d = (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q    <= '0;
      pal_index_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rgb_q   <= '0;
    end else if (flush) begin
      // Frame start: in-flight lookups are dropped, data registers keep their value.
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q    <= rr_ptr_d;
        pal_index_q <= win_index;
        s1_owner_q  <= winner;
      end
      s1_valid_q <= accept;
      if (s1_valid_q) begin
        rsp_rgb_q   <= {pal_red, pal_green, pal_blue};
        rsp_valid_q <= N_REQ'(1) << s1_owner_q;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign pal_index = pal_index_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_red   = rsp_rgb_q[3*CW-1 -: CW];
  assign rsp_green = rsp_rgb_q[2*CW-1 -: CW];
  assign rsp_blue  = rsp_rgb_q[CW-1:0];
  assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
Shares one 16-entry, 12-bit background palette ROM between up to N_REQ pixel-pipeline requesters (background, player sprites, ball, score overlay).
- Each cycle, a round-robin arbiter accepts one 4-bit colour index.
- It drives the index to the combinational palette.
- It returns the registered RGB to the winning requester two cycles after grant.
- Sits between the sprite/background address generators and the VGA colour mux.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 4, palette index width
CW, 4, width of each colour channel

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous frame-start flush; drops in-flight lookups, pointer to 0
req  in  N_REQ  per-requester lookup request; held until granted
index  in  N_REQ*IDX_W  packed indices; requester i at [i*IDX_W +: IDX_W]
gnt  out  N_REQ  one-hot combinational grant; a request is accepted when req[i]&gnt[i]
pal_index  out  IDX_W  registered index driven to palette
pal_red, pal_green, pal_blue  in  CW each  combinational palette outputs for pal_index
rsp_valid  out  N_REQ  one-hot registered response strobe
rsp_red, rsp_green, rsp_blue  out  CW each  registered colour for the rsp_valid owner
busy  out  1  high while any lookup is in stages S1/S2

Behaviour:
- Reset (Reset_n low, async):
  - pal_index=0, rsp_valid=0, rsp_rgb=0, busy=0.
  - Both stage-valid flags cleared; rr_ptr=0.
- Arbitration (combinational):
  - Search req starting at rr_ptr, wrapping modulo N_REQ; first set bit wins.
  - gnt is one-hot for the winner, or all zero if req==0 or flush==1.
  - gnt never asserts without the matching req.
- Pointer update on accept (edge where any gnt bit is set):
  - rr_ptr <= winner+1; winner==N_REQ-1 wraps to 0.
  - With no accept, rr_ptr holds.
- Stage S1 (edge after accept):
  - pal_index <= index of winner; s1_valid <= 1; s1_owner <= winner.
  - With no accept: s1_valid <= 0, pal_index holds.
- Stage S2 (next edge):
  - If s1_valid: rsp_rgb <= {pal_red, pal_green, pal_blue}, rsp_valid <= onehot(s1_owner).
  - Else: rsp_valid <= 0, rsp_rgb holds.
- Timing and throughput:
  - Latency is fixed: gnt in cycle t, rsp_valid in cycle t+2.
  - Throughput is one lookup per cycle; back-to-back grants are allowed.
  - A single requester holding req continuously is granted every cycle when no one else requests.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,...
  - Each requester waits at most N_REQ-1 cycles.
- busy = s1_valid | s2_valid, where s2_valid = |rsp_valid.
- flush (synchronous, highest priority):
  - gnt forced to 0.
  - On the edge: s1_valid<=0, rsp_valid<=0, rr_ptr<=0.
  - pal_index and rsp_rgb hold.
  - Lookups accepted before flush never produce rsp_valid.
- Simultaneous events:
  - A new accept and an S2 response in the same cycle are independent.
  - req dropping in the same cycle as its grant is still a valid accept.
  - req deasserted without gnt is withdrawn silently.
- Reset mid-operation:
  - In-flight lookups are discarded; no rsp_valid after Reset_n rises until a new accept.
- Width rules:
  - winner/rr_ptr width is clog2(N_REQ), minimum 1.
  - Index slices are unsigned; no arithmetic on colour data.

Test Plan:
- Reset then idle: req=0 for 10 cycles -> gnt=0, rsp_valid=0, busy=0, pal_index=0.
- Single lookup: req=0001, index0=4'h6 at t -> gnt=0001 at t; pal_index=6 at t+1; rsp_valid=0001, rsp={E,7,6} at t+2.
- Round-robin: req=1111 held, index i = i+1 -> grant order 0,1,2,3,0; rsp colours {8,E,F},{D,C,C},{A,A,A},{F,F,F} repeating, each two cycles after its grant.
- Pointer wrap/skip: grant requester 3, then req=0101 -> requester 0 granted next, then 2, then 0.
- Flush: accept index 4'hF for req0 at t, flush=1 at t+1 -> no rsp_valid at t+2; gnt=0 during flush; next accept starts search at requester 0.
- Async reset mid-stream: Reset_n low between clock edges while S1 and S2 valid -> rsp_valid and busy drop immediately; no stale response after release.
